spart_driver: RTL and testbench
===============================

# spart_driver

Bus-side controller that sequences a single SPART through its 2-bit address / 8-bit bidirectional data bus. After reset it programs the baud divisor from a 2-bit selection, then runs an echo loop: received bytes are read from the SPART, buffered in a 4-entry FIFO, and written back for transmission when the transmitter is ready. It sits between the board-level switches and the SPART instance at the processor-bus position.

## Interface
- DIV_4800, 16'd1301, divisor for br_cfg=00 (100 MHz clock, 16x oversample)
- DIV_9600, 16'd650, divisor for br_cfg=01
- DIV_19200, 16'd324, divisor for br_cfg=10
- DIV_38400, 16'd161, divisor for br_cfg=11
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- br_cfg  in  2  baud select; asynchronous, double-flop synchronized internally
- rda  in  1  SPART receive data available
- tbr  in  1  SPART transmit buffer ready
- iocs  out  1  SPART chip select, high only during an access cycle
- iorw  out  1  1 = read, 0 = write
- ioaddr  out  2  00 data, 01 status, 10 divisor low, 11 divisor high
- databus  inout  8  driven only when iocs=1 and iorw=0, else high-Z
- overrun  out  1  sticky: a received byte was dropped because the FIFO was full

## Operation
- States: CFG_LO, CFG_HI, IDLE, RD, WR. Reset state CFG_LO.
- CFG_LO: iocs=1, iorw=0, ioaddr=10, databus=div[7:0]. Latches the synchronized br_cfg as the applied value. Next state CFG_HI.
- CFG_HI: iocs=1, iorw=0, ioaddr=11, databus=div[15:8]. Next state IDLE.
- IDLE: iocs=0, iorw=1, ioaddr=01, databus high-Z. Accesses are issued only if the previous cycle was IDLE. Priority when eligible:
  - synchronized br_cfg != applied value -> CFG_LO
  - rda=1 -> RD
  - tbr=1 and FIFO not empty -> WR
  - otherwise stay.
- RD: iocs=1, iorw=1, ioaddr=00. databus is sampled at the closing edge and pushed to the FIFO. If the FIFO is full, the byte is discarded and overrun is set. The read still occurs so that rda clears. Next state IDLE.
- WR: iocs=1, iorw=0, ioaddr=00, databus=FIFO head. The head is popped at the closing edge. Next state IDLE.
- FIFO: 4 x 8, 2-bit read/write pointers with wrap, 3-bit count (0..4). Push and pop never occur in the same cycle.
- overrun clears only on reset.

## Timing
- Reset values (asynchronous, immediate on rst_n=0):
  - iocs=0, iorw=1, ioaddr=01, databus high-Z
  - overrun=0, FIFO empty, applied br_cfg=00
  - FSM in CFG_LO; the first access occurs on the first clk edge after rst_n rises.
- Configuration after reset takes 2 cycles (CFG_LO then CFG_HI). The first IDLE access decision is 2 cycles later, because IDLE must be held one full cycle.
- Every access is exactly one clock. Consecutive accesses are separated by at least one IDLE cycle. The minimum access spacing is 2 cycles, which gives the SPART one cycle to drop rda or tbr.
- Echo latency, from rda sampled high in an eligible IDLE with tbr=1:
  - RD on the next cycle
  - IDLE for one cycle
  - WR on the following cycle, so the byte is on databus 3 cycles after rda is sampled.
- br_cfg change: takes effect at most 2 synchronizer cycles plus the current access plus one IDLE later. A change during RD or WR never corrupts that access. A change between CFG_LO and CFG_HI is caught on the next IDLE and triggers a full reprogram.
- rst_n asserted mid-access immediately releases databus and deasserts iocs. An in-flight push or pop is lost.

## Test plan
- Reset with br_cfg=01, then release: cycle 1 writes 0x8A to addr 10, cycle 2 writes 0x02 to addr 11, then iocs stays 0 with ioaddr=01.
- Single echo with tbr=1, rda pulse with byte 0x55: one read at addr 00, then a write of 0x55 to addr 00 exactly 2 cycles later; overrun stays 0.
- Buffering with tbr=0: receive 0x11, 0x22, 0x33, 0x44, 0x66. Five reads occur, overrun=1. After tbr=1, exactly four writes occur in the order 11, 22, 33, 44, and FIFO count returns to 0.
- Simultaneous rda=1 and tbr=1 with a non-empty FIFO: RD is issued before WR, and accesses never fall on adjacent cycles.
- Change br_cfg 01->11 while idle: within 4 cycles, writes 0xA1 to addr 10 and 0x00 to addr 11; echo then resumes.
- rst_n low during WR: databus goes to Z and iocs=0 with no clock edge; after release, the divisor sequence repeats and the FIFO is empty.

Source files
------------

// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor from br_cfg, then echoes received
// bytes back through a 4-entry FIFO using one-clock bus accesses.
//
//   state  | meaning
//   CFG_LO | write divisor low byte (addr 10), latch applied br_cfg
//   CFG_HI | write divisor high byte (addr 11)
//   IDLE   | bus released; picks the next access at its closing edge
//   RD     | read received byte (addr 00), push to FIFO
//   WR     | write FIFO head (addr 00), pop
module spart_driver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       overrun
);

    localparam logic [15:0] DIV_4800  = 16'd1301;
    localparam logic [15:0] DIV_9600  = 16'd650;
    localparam logic [15:0] DIV_19200 = 16'd324;
    localparam logic [15:0] DIV_38400 = 16'd161;

    localparam logic [2:0] CFG_LO = 3'd0;
    localparam logic [2:0] CFG_HI = 3'd1;
    localparam logic [2:0] IDLE   = 3'd2;
    localparam logic [2:0] RD     = 3'd3;
    localparam logic [2:0] WR     = 3'd4;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [1:0]  br_s1;
    logic [1:0]  br_s2;
    logic [1:0]  br_app;
    logic [15:0] div_lo_src;
    logic [15:0] div_hi_src;

    logic [7:0]  fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  fifo_cnt;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;

    logic [7:0]  dout;
    logic        drive;

    function automatic logic [15:0] div_sel(input logic [1:0] sel);
        case (sel)
            2'b00:   div_sel = DIV_4800;
            2'b01:   div_sel = DIV_9600;
            2'b10:   div_sel = DIV_19200;
            default: div_sel = DIV_38400;
        endcase
    endfunction

    // Synchronizer flops carry no reset so the switch setting is already valid
    // when the first divisor write goes out right after reset release.
    always_ff @(posedge clk) begin
        br_s1 <= br_cfg;
        br_s2 <= br_s1;
    end

    assign fifo_full  = (fifo_cnt == 3'd4);
    assign fifo_empty = (fifo_cnt == 3'd0);
    assign push       = (state == RD) && !fifo_full;
    assign pop        = (state == WR) && !fifo_empty;

    always_comb begin
        state_nxt = state;
        case (state)
            CFG_LO: state_nxt = CFG_HI;
            CFG_HI: state_nxt = IDLE;
            IDLE: begin
                if (br_s2 != br_app)
                    state_nxt = CFG_LO;
                else if (rda)
                    state_nxt = RD;
                else if (tbr && !fifo_empty)
                    state_nxt = WR;
                else
                    state_nxt = IDLE;
            end
            RD:      state_nxt = IDLE;
            WR:      state_nxt = IDLE;
            default: state_nxt = CFG_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CFG_LO;
            br_app   <= 2'b00;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
            overrun  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == CFG_LO)
                br_app <= br_s2;
            if (push) begin
                wr_ptr   <= wr_ptr + 2'd1;
                fifo_cnt <= fifo_cnt + 3'd1;
            end else if (pop) begin
                rd_ptr   <= rd_ptr + 2'd1;
                fifo_cnt <= fifo_cnt - 3'd1;
            end
            if ((state == RD) && fifo_full)
                overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= databus;
    end

    assign div_lo_src = div_sel(br_s2);
    assign div_hi_src = div_sel(br_app);

    // Outputs are gated by rst_n so asserting reset mid-access releases the bus
    // without waiting for a clock edge.
    always_comb begin
        iocs   = 1'b0;
        iorw   = 1'b1;
        ioaddr = ADDR_STATUS;
        dout   = 8'h00;
        if (rst_n) begin
            case (state)
                CFG_LO: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = ADDR_DIV_LO;
                    dout   = div_lo_src[7:0];
                end
                CFG_HI: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = ADDR_DIV_HI;
                    dout   = div_hi_src[15:8];
                end
                RD: begin
                    iocs   = 1'b1;
                    iorw   = 1'b1;
                    ioaddr = ADDR_DATA;
                end
                WR: begin
                    iocs   = 1'b1;
                    iorw   = 1'b0;
                    ioaddr = ADDR_DATA;
                    dout   = fifo_mem[rd_ptr];
                end
                default: begin
                    iocs   = 1'b0;
                    iorw   = 1'b1;
                    ioaddr = ADDR_STATUS;
                end
            endcase
        end
    end

    assign drive   = iocs && !iorw;
    assign databus = drive ? dout : 8'hzz;

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: a minimal SPART model drives databus on reads,
// and each step checks the bus cycle against hand-computed values.
module tb_spart_driver;

    logic       clk;
    logic       rst_n;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       overrun;

    logic [7:0] rx_byte;
    logic       probe;
    int         total;
    int         bad;
    logic [7:0] bytes_in [5];

    spart_driver dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .br_cfg  (br_cfg),
        .rda     (rda),
        .tbr     (tbr),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .overrun (overrun)
    );

    // SPART side: returns rx_byte on reads; probe forces a drive to prove release.
    assign databus = (probe || (iocs && iorw)) ? rx_byte : 8'hzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_iocs"}, {7'd0, iocs}, 8'h00);
        chk({tag, "_addr"}, {6'd0, ioaddr}, 8'h01);
    endtask

    task automatic chk_wr(input string tag, input logic [1:0] addr, input logic [7:0] data);
        chk({tag, "_iocs"}, {7'd0, iocs}, 8'h01);
        chk({tag, "_iorw"}, {7'd0, iorw}, 8'h00);
        chk({tag, "_addr"}, {6'd0, ioaddr}, {6'd0, addr});
        chk({tag, "_data"}, databus, data);
    endtask

    task automatic chk_rd(input string tag);
        chk({tag, "_iocs"}, {7'd0, iocs}, 8'h01);
        chk({tag, "_iorw"}, {7'd0, iorw}, 8'h01);
        chk({tag, "_addr"}, {6'd0, ioaddr}, 8'h00);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bytes_in[0] = 8'h11;
        bytes_in[1] = 8'h22;
        bytes_in[2] = 8'h33;
        bytes_in[3] = 8'h44;
        bytes_in[4] = 8'h66;
        rst_n   = 1'b0;
        br_cfg  = 2'b01;
        rda     = 1'b0;
        tbr     = 1'b0;
        rx_byte = 8'h00;
        probe   = 1'b0;

        // reset state
        repeat (4) tick();
        probe = 1'b1; rx_byte = 8'hC3; #1;
        chk("rst_bus_released", databus, 8'hC3);
        probe = 1'b0;
        chk_idle("rst");
        chk("rst_iorw", {7'd0, iorw}, 8'h01);
        chk("rst_overrun", {7'd0, overrun}, 8'h00);
        chk("rst_cnt", {5'd0, dut.fifo_cnt}, 8'h00);

        // divisor programming, br_cfg=01 -> 650 = 0x028A
        rst_n = 1'b1; #1;
        chk_wr("cfg_lo", 2'b10, 8'h8A);
        tick();
        chk_wr("cfg_hi", 2'b11, 8'h02);
        tick();
        chk_idle("post_cfg0");
        tick();
        chk_idle("post_cfg1");

        // single echo
        rx_byte = 8'h55; rda = 1'b1; tbr = 1'b1;
        tick();
        chk_rd("echo_rd");
        rda = 1'b0;
        tick();
        chk_idle("echo_gap");
        tick();
        chk_wr("echo_wr", 2'b00, 8'h55);
        tbr = 1'b0;
        tick();
        chk_idle("echo_after");
        chk("echo_overrun", {7'd0, overrun}, 8'h00);
        chk("echo_cnt", {5'd0, dut.fifo_cnt}, 8'h00);

        // buffering with transmitter busy, fifth byte overruns
        for (int i = 0; i < 5; i++) begin
            rx_byte = bytes_in[i]; rda = 1'b1;
            tick();
            chk_rd("buf_rd");
            rda = 1'b0;
            tick();
            chk_idle("buf_gap");
            chk("buf_overrun", {7'd0, overrun}, (i == 4) ? 8'h01 : 8'h00);
        end
        chk("buf_cnt_full", {5'd0, dut.fifo_cnt}, 8'h04);
        tbr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_wr("drain_wr", 2'b00, bytes_in[i]);
            tick();
            chk_idle("drain_gap");
        end
        tick();
        chk_idle("drain_no_extra0");
        tick();
        chk_idle("drain_no_extra1");
        chk("drain_cnt", {5'd0, dut.fifo_cnt}, 8'h00);
        chk("drain_overrun_sticky", {7'd0, overrun}, 8'h01);
        tbr = 1'b0;

        // rda and tbr together with a non-empty FIFO: read wins, no adjacent accesses
        rx_byte = 8'h77; rda = 1'b1;
        tick();
        chk_rd("pri_pre_rd");
        rda = 1'b0;
        tick();
        rx_byte = 8'h88; rda = 1'b1; tbr = 1'b1;
        tick();
        chk_rd("pri_rd");
        rda = 1'b0;
        tick();
        chk_idle("pri_gap0");
        tick();
        chk_wr("pri_wr0", 2'b00, 8'h77);
        tick();
        chk_idle("pri_gap1");
        tick();
        chk_wr("pri_wr1", 2'b00, 8'h88);
        tbr = 1'b0;
        tick();
        chk_idle("pri_after");
        chk("pri_cnt", {5'd0, dut.fifo_cnt}, 8'h00);

        // baud change 01 -> 11 while idle: 161 = 0x00A1
        br_cfg = 2'b11;
        tick();
        chk_idle("br_sync0");
        tick();
        chk_idle("br_sync1");
        tick();
        chk_wr("br_lo", 2'b10, 8'hA1);
        tick();
        chk_wr("br_hi", 2'b11, 8'h00);
        tick();
        chk_idle("br_after");
        rx_byte = 8'h5A; rda = 1'b1; tbr = 1'b1;
        tick();
        chk_rd("br_echo_rd");
        rda = 1'b0;
        tick();
        chk_idle("br_echo_gap");
        tick();
        chk_wr("br_echo_wr", 2'b00, 8'h5A);
        tbr = 1'b0;
        tick();
        chk_idle("br_echo_after");

        // reset asserted in the middle of a write
        rx_byte = 8'h99; rda = 1'b1;
        tick();
        chk_rd("mid_rd");
        rda = 1'b0;
        tick();
        tbr = 1'b1;
        tick();
        chk_wr("mid_wr", 2'b00, 8'h99);
        #2;
        rst_n = 1'b0; tbr = 1'b0;
        #1;
        chk("mid_rst_iocs", {7'd0, iocs}, 8'h00);
        probe = 1'b1; rx_byte = 8'h3C; #1;
        chk("mid_rst_bus_released", databus, 8'h3C);
        probe = 1'b0;
        chk("mid_rst_cnt", {5'd0, dut.fifo_cnt}, 8'h00);
        repeat (2) tick();
        rst_n = 1'b1; #1;
        chk_wr("re_cfg_lo", 2'b10, 8'hA1);
        tick();
        chk_wr("re_cfg_hi", 2'b11, 8'h00);
        tick();
        chk_idle("re_idle");
        chk("re_cnt", {5'd0, dut.fifo_cnt}, 8'h00);
        chk("re_overrun", {7'd0, overrun}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
